segment_dispatcher: RTL and testbench
=====================================

SEGMENT_DISPATCHER -- requirements
Module: segment_dispatcher

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have parameter EOS_TIMEOUT, default 255, max cycles waiting for eos.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port instr_valid  input  1  instr word present.
REQ-006 SHALL have port instr  input  32  MIPS instruction word.
REQ-007 SHALL have port instr_ready  output  1  word accepted this cycle.
REQ-008 SHALL have port pc  output  PC_W  address of the next instruction to fetch.
REQ-009 SHALL have port opcode  output  6  segment index to the microcode sequencer.
REQ-010 SHALL have port sos  output  1  start-of-segment pulse.
REQ-011 SHALL have port eos  input  1  end-of-segment level from the sequencer.
REQ-012 SHALL have port halted  output  1  halt instruction executed.
REQ-013 SHALL have port err  output  1  sticky: unsupported instruction or eos timeout.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT_EOS, HALT, ERROR.
REQ-015 IDLE SHALL go to FETCH one cycle after reset release.
REQ-016 FETCH SHALL assert instr_ready; on instr_valid&&instr_ready it latches instr, decodes, and goes to ISSUE (valid index) or ERROR (unsupported).
REQ-017 Decode SHALL map: op 0x23 LW->0, 0x2B SW->1; op 0x00 with funct 0x20 ADD->2, 0x22 SUB->3, 0x24 AND->4, 0x25 OR->5, 0x2A SLT->6; op 0x04 BEQ->7, 0x02 J->8; instr==32'hFFFF_FFFF HALT->6'h3F.
REQ-018 Any other encoding, including an R-type with another funct, SHALL be unsupported.
REQ-019 opcode SHALL be registered, updated only on FETCH acceptance, and held stable until the next acceptance.
REQ-020 ISSUE SHALL drive sos=1 for exactly one cycle, then go to WAIT_EOS; sos SHALL be a flop output, glitch-free.
REQ-021 HALT decode SHALL skip ISSUE, go to HALT, set halted=1, and never assert sos.
REQ-022 WAIT_EOS SHALL sample eos from its first cycle; on eos=1, pc<=pc+1 (wraps modulo 2^PC_W) and go to FETCH.
REQ-023 A single-microinstruction segment (eos=1 on first WAIT_EOS cycle) SHALL complete with pc advance in that cycle.
REQ-024 A 16-bit wait counter SHALL clear on ISSUE and increment each WAIT_EOS cycle without eos; reaching EOS_TIMEOUT SHALL go to ERROR.
REQ-025 HALT and ERROR SHALL be terminal until reset; instr_ready=0 and sos=0 there.
REQ-026 instr_ready SHALL be 1 only in FETCH; instr_valid outside FETCH SHALL be ignored.
REQ-027 Latency SHALL be accept (cycle N), sos (N+1), earliest pc advance (N+2).

Reset
REQ-028 On rst_n=0, at any time including mid-segment, state=IDLE, pc=0, opcode=0, sos=0, instr_ready=0, halted=0, err=0, wait counter=0.
REQ-029 Reset deassertion SHALL take effect on the next rising clk edge; no sos during or in the first cycle after reset.

Structure
REQ-030 A shared package SHALL hold the state enum, MIPS opcode/funct constants, segment-index constants, and HALT_WORD.
REQ-031 Decode SHALL be a separate combinational sub-module, mips_seg_decode (instr in; index and supported out).

Verification
REQ-032 LW (32'h8C01_0004) accepted, eos=1 after 4 WAIT_EOS cycles -> opcode=0, one sos pulse, pc 0->1 on the 4th WAIT_EOS cycle.
REQ-033 SW (32'hAC01_0004), eos=1 immediately -> opcode=1, pc advances 2 cycles after acceptance.
REQ-034 ADD (32'h0022_1820) then word 32'h0022_1821 -> opcode=2 segment completes; second word gives err=1 with no second sos.
REQ-035 32'hFFFF_FFFF -> halted=1, sos never asserted, instr_ready=0 thereafter.
REQ-036 EOS_TIMEOUT=8, eos held 0 -> err=1 after 8 WAIT_EOS cycles; rst_n pulse clears all outputs to 0.
REQ-037 pc at 8'hFF completing a segment -> pc=8'h00; rst_n asserted mid-WAIT_EOS -> IDLE, pc=0, sos=0.

Source files
------------

// File: rtl/segment_dispatcher_pkg.sv
// Shared definitions for the segment dispatcher: FSM state encoding, MIPS
// opcode/funct field values, microcode segment indices and the halt word.
package segment_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_EOS,
      ST_HALT,
      ST_ERROR
   } state_t;

   localparam int unsigned WAIT_W = 16;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [5:0] SEG_LW   = 6'd0;
   localparam logic [5:0] SEG_SW   = 6'd1;
   localparam logic [5:0] SEG_ADD  = 6'd2;
   localparam logic [5:0] SEG_SUB  = 6'd3;
   localparam logic [5:0] SEG_AND  = 6'd4;
   localparam logic [5:0] SEG_OR   = 6'd5;
   localparam logic [5:0] SEG_SLT  = 6'd6;
   localparam logic [5:0] SEG_BEQ  = 6'd7;
   localparam logic [5:0] SEG_J    = 6'd8;
   localparam logic [5:0] SEG_HALT = 6'h3F;

   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_seg_decode.sv
// Combinational MIPS instruction decoder: maps an instruction word onto a
// microcode segment index.
//   instr     : 32-bit MIPS instruction word
//   index     : segment index (0 when unsupported)
//   supported : 1 when the encoding has a segment (including HALT)
module mips_seg_decode
   import segment_dispatcher_pkg::*;
(
   input  logic [31:0] instr,
   output logic [5:0]  index,
   output logic        supported
);

   always_comb begin
      index     = '0;
      supported = 1'b0;
      // The halt word carries op 0x3F, so it must be matched before the op field.
      if (instr == HALT_WORD) begin
         index     = SEG_HALT;
         supported = 1'b1;
      end else begin
         unique case (instr[31:26])
            OP_LW:  begin index = SEG_LW;  supported = 1'b1; end
            OP_SW:  begin index = SEG_SW;  supported = 1'b1; end
            OP_BEQ: begin index = SEG_BEQ; supported = 1'b1; end
            OP_J:   begin index = SEG_J;   supported = 1'b1; end
            OP_RTYPE: begin
               unique case (instr[5:0])
                  FN_ADD:  begin index = SEG_ADD; supported = 1'b1; end
                  FN_SUB:  begin index = SEG_SUB; supported = 1'b1; end
                  FN_AND:  begin index = SEG_AND; supported = 1'b1; end
                  FN_OR:   begin index = SEG_OR;  supported = 1'b1; end
                  FN_SLT:  begin index = SEG_SLT; supported = 1'b1; end
                  default: begin index = '0;      supported = 1'b0; end
               endcase
            end
            default: begin index = '0; supported = 1'b0; end
         endcase
      end
   end

endmodule

// File: rtl/segment_dispatcher.sv
// Fetches MIPS instruction words, decodes each into a microcode segment index,
// starts the segment with a one-cycle sos pulse and waits for eos before
// advancing pc. HALT and unsupported/timeout conditions are terminal.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   instr_valid  : instruction word present on instr
//   instr        : 32-bit MIPS instruction word
//   instr_ready  : word accepted this cycle (FETCH only)
//   pc           : address of the next instruction to fetch
//   opcode       : segment index to the microcode sequencer
//   sos          : start-of-segment pulse
//   eos          : end-of-segment level from the sequencer
//   halted       : halt instruction executed
//   err          : sticky unsupported-instruction / eos-timeout flag
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | one cycle after reset release
// FETCH    | instr_ready=1, waiting for a word
// ISSUE    | sos=1 for this single cycle
// WAIT_EOS | segment running, counting cycles until eos or timeout
// HALT     | halt word executed, terminal until reset
// ERROR    | unsupported word or eos timeout, terminal until reset
module segment_dispatcher
   import segment_dispatcher_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int EOS_TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   output logic            instr_ready,
   output logic [PC_W-1:0] pc,
   output logic [5:0]      opcode,
   output logic            sos,
   input  logic            eos,
   output logic            halted,
   output logic            err
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EOS_TIMEOUT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [5:0]        dec_index;
   logic              dec_supported;

   mips_seg_decode u_decode (
      .instr     (instr),
      .index     (dec_index),
      .supported (dec_supported)
   );

   // Outputs are flops set on the transition into the state that owns them,
   // so instr_ready and sos track FETCH and ISSUE exactly without glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= '0;
         opcode      <= '0;
         sos         <= 1'b0;
         instr_ready <= 1'b0;
         halted      <= 1'b0;
         err         <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state       <= ST_FETCH;
               instr_ready <= 1'b1;
            end
            ST_FETCH: begin
               if (instr_valid && instr_ready) begin
                  opcode      <= dec_index;
                  instr_ready <= 1'b0;
                  if (!dec_supported) begin
                     state <= ST_ERROR;
                     err   <= 1'b1;
                  end else if (dec_index == SEG_HALT) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else begin
                     state <= ST_ISSUE;
                     sos   <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               sos      <= 1'b0;
               wait_cnt <= '0;
               state    <= ST_WAIT_EOS;
            end
            ST_WAIT_EOS: begin
               if (eos) begin
                  pc          <= pc + PC_W'(1);
                  state       <= ST_FETCH;
                  instr_ready <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
                  if (wait_cnt == WAIT_LAST) begin
                     state <= ST_ERROR;
                     err   <= 1'b1;
                  end
               end
            end
            ST_HALT, ST_ERROR: begin
               instr_ready <= 1'b0;
               sos         <= 1'b0;
            end
            default: begin
               state       <= ST_ERROR;
               err         <= 1'b1;
               instr_ready <= 1'b0;
               sos         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_segment_dispatcher.sv
module tb_segment_dispatcher;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [7:0]  pc;
   logic [5:0]  opcode;
   logic        sos;
   logic        eos = 1'b0;
   logic        halted;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   int sos_cnt  = 0;
   int sos_base;

   segment_dispatcher #(.PC_W(8), .EOS_TIMEOUT(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .pc          (pc),
      .opcode      (opcode),
      .sos         (sos),
      .eos         (eos),
      .halted      (halted),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (sos === 1'b1) sos_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".pc"}, 32'(pc), 32'h0);
      check({tag, ".opcode"}, 32'(opcode), 32'h0);
      check({tag, ".sos"}, 32'(sos), 32'h0);
      check({tag, ".ready"}, 32'(instr_ready), 32'h0);
      check({tag, ".halted"}, 32'(halted), 32'h0);
      check({tag, ".err"}, 32'(err), 32'h0);
   endtask

   // Accepts w in FETCH, then eos on the first WAIT_EOS cycle; ends in FETCH.
   task automatic run_seg(input logic [31:0] w);
      instr_valid = 1'b1; instr = w;
      step();
      instr_valid = 1'b0; eos = 1'b1;
      step();
      step();
      eos = 1'b0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   logic [31:0] words [5] = '{32'h0022_1822, 32'h0022_1824, 32'h0022_1825,
                              32'h0022_182A, 32'h1022_0004};
   logic [5:0]  idxs  [5] = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd7};

   initial begin
      // Reset state
      step();
      step();
      check_all_zero("reset");
      rst_n = 1'b1;
      #1;
      check("idle.ready", 32'(instr_ready), 32'h0);
      step();
      check("fetch.ready", 32'(instr_ready), 32'h1);
      check("fetch.sos", 32'(sos), 32'h0);

      // LW, eos on the 4th WAIT_EOS cycle
      sos_base = sos_cnt;
      instr_valid = 1'b1; instr = 32'h8C01_0004;
      step();
      instr_valid = 1'b0;
      check("lw.sos", 32'(sos), 32'h1);
      check("lw.opcode", 32'(opcode), 32'h0);
      check("lw.ready", 32'(instr_ready), 32'h0);
      step();
      check("lw.w1.sos", 32'(sos), 32'h0);
      step();
      step();
      check("lw.w3.pc", 32'(pc), 32'h0);
      step();
      eos = 1'b1;
      check("lw.w4.pc", 32'(pc), 32'h0);
      step();
      eos = 1'b0;
      check("lw.pc", 32'(pc), 32'h1);
      check("lw.ready", 32'(instr_ready), 32'h1);
      check("lw.sos_cnt", 32'(sos_cnt - sos_base), 32'h1);

      // SW, eos immediately: pc advances two edges after acceptance
      instr_valid = 1'b1; instr = 32'hAC01_0004;
      step();
      instr_valid = 1'b0; eos = 1'b1;
      check("sw.opcode", 32'(opcode), 32'h1);
      check("sw.sos", 32'(sos), 32'h1);
      step();
      check("sw.w1.pc", 32'(pc), 32'h1);
      step();
      eos = 1'b0;
      check("sw.pc", 32'(pc), 32'h2);

      // Remaining decodes
      for (int i = 0; i < 5; i++) begin
         instr_valid = 1'b1; instr = words[i];
         step();
         instr_valid = 1'b0; eos = 1'b1;
         check("dec.opcode", 32'(opcode), 32'(idxs[i]));
         step();
         step();
         eos = 1'b0;
      end
      check("dec.pc", 32'(pc), 32'h7);
      instr_valid = 1'b1; instr = 32'h0800_0010;
      step();
      instr_valid = 1'b0; eos = 1'b1;
      check("j.opcode", 32'(opcode), 32'h8);
      step();
      step();
      eos = 1'b0;

      // ADD, then unsupported R-type funct
      sos_base = sos_cnt;
      instr_valid = 1'b1; instr = 32'h0022_1820;
      step();
      instr_valid = 1'b0; eos = 1'b1;
      check("add.opcode", 32'(opcode), 32'h2);
      step();
      step();
      eos = 1'b0;
      check("add.pc", 32'(pc), 32'h9);
      instr_valid = 1'b1; instr = 32'h0022_1821;
      step();
      check("bad.err", 32'(err), 32'h1);
      check("bad.ready", 32'(instr_ready), 32'h0);
      step();
      step();
      instr_valid = 1'b0;
      check("bad.sos_cnt", 32'(sos_cnt - sos_base), 32'h1);
      check("bad.err_sticky", 32'(err), 32'h1);
      check("bad.pc", 32'(pc), 32'h9);

      // Async reset clears everything
      rst_n = 1'b0;
      #1;
      check_all_zero("rst1");
      step();
      rst_n = 1'b1;
      step();
      check("rst1.ready", 32'(instr_ready), 32'h1);

      // HALT
      sos_base = sos_cnt;
      instr_valid = 1'b1; instr = 32'hFFFF_FFFF;
      step();
      check("halt.halted", 32'(halted), 32'h1);
      check("halt.opcode", 32'(opcode), 32'h3F);
      check("halt.ready", 32'(instr_ready), 32'h0);
      instr = 32'h8C01_0004;
      step();
      step();
      step();
      instr_valid = 1'b0;
      check("halt.ready_hold", 32'(instr_ready), 32'h0);
      check("halt.sos_cnt", 32'(sos_cnt - sos_base), 32'h0);
      check("halt.err", 32'(err), 32'h0);
      reset_pulse();

      // Unsupported opcode (ADDI)
      instr_valid = 1'b1; instr = 32'h2022_0004;
      step();
      instr_valid = 1'b0;
      check("addi.err", 32'(err), 32'h1);
      check("addi.sos", 32'(sos), 32'h0);
      reset_pulse();

      // EOS timeout = 8 WAIT_EOS cycles
      instr_valid = 1'b1; instr = 32'h0022_1825;
      step();
      instr_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("to.w8.err", 32'(err), 32'h0);
      step();
      check("to.err", 32'(err), 32'h1);
      check("to.ready", 32'(instr_ready), 32'h0);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst2");
      step();
      rst_n = 1'b1;
      step();

      // pc wrap
      for (int i = 0; i < 255; i++) run_seg(32'hAC01_0004);
      check("wrap.pc_ff", 32'(pc), 32'hFF);
      run_seg(32'h8C01_0004);
      check("wrap.pc_00", 32'(pc), 32'h00);
      check("wrap.ready", 32'(instr_ready), 32'h1);

      // Reset in the middle of WAIT_EOS
      run_seg(32'h0022_1820);
      instr_valid = 1'b1; instr = 32'h0022_1824;
      step();
      instr_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_all_zero("rst3");
      step();
      rst_n = 1'b1;
      #1;
      check("rst3.release.sos", 32'(sos), 32'h0);
      step();
      check("rst3.ready", 32'(instr_ready), 32'h1);
      check("rst3.sos", 32'(sos), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
